seq_alu: RTL and testbench

//   Parametrised, multi-cycle integer ALU that supports add, sub, mul and rem (unsigned operands).

---
 rtl/seq_alu.sv | 134 +++++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU (add, sub, mul, rem) with valid/ready request and response ports.
// Mul is a W-step shift-add; rem is a W-step restoring divider sharing the same accumulator.
module seq_alu #(
   parameter int W     = 3,
   parameter int RES_W = 2*W,
   parameter int CNT_W = $clog2(W+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     num1,
   input  logic [W-1:0]     num2,
   input  logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] result,
   output logic             zeroFlag,
   output logic             negFlag,
   output logic             divByZeroFlag
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_REM = 2'b11;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT             state;
   stateT             nextState;
   logic [W-1:0]      aReg;
   logic [W-1:0]      bReg;
   logic              mulOp;
   logic [CNT_W-1:0]  counter;
   logic [RES_W-1:0]  accReg;

   logic              accept;
   logic              longOp;
   logic [RES_W-1:0]  addRes;
   logic [RES_W-1:0]  subRes;
   logic [W:0]        mulSum;
   logic [RES_W-1:0]  mulNext;
   logic [W:0]        remShift;
   logic [W:0]        remDiff;
   logic [W-1:0]      remNext;
   logic [RES_W-1:0]  stepNext;

   assign accept = in_valid && in_ready;
   assign longOp = (sel == OP_MUL) || ((sel == OP_REM) && (num2 != '0));
   assign addRes = {{W{1'b0}}, num1} + {{W{1'b0}}, num2};
   assign subRes = {{W{1'b0}}, num1} - {{W{1'b0}}, num2};

   // Mul: add multiplicand into the upper half, then shift the whole accumulator right.
   assign mulSum  = {1'b0, accReg[RES_W-1:W]} + {1'b0, (aReg[0] ? bReg : {W{1'b0}})};
   assign mulNext = {mulSum, accReg[W-1:1]};

   // Rem: partial remainder lives in the low half; dividend bits shift in MSB first.
   assign remShift = {accReg[W-1:0], aReg[W-1]};
   assign remDiff  = remShift - {1'b0, bReg};
   assign remNext  = remDiff[W] ? remShift[W-1:0] : remDiff[W-1:0];
   assign stepNext = mulOp ? mulNext : {{W{1'b0}}, remNext};

   assign result = accReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nextState = longOp ? BUSY : DONE;
         end
         BUSY: begin
            if (counter == CNT_ONE) nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aReg          <= '0;
         bReg          <= '0;
         mulOp         <= 1'b0;
         counter       <= '0;
         accReg        <= '0;
         zeroFlag      <= 1'b0;
         negFlag       <= 1'b0;
         divByZeroFlag <= 1'b0;
      end else if (accept) begin
         aReg          <= num1;
         bReg          <= num2;
         mulOp         <= (sel == OP_MUL);
         counter       <= CNT_INIT;
         accReg        <= '0;
         zeroFlag      <= 1'b0;
         negFlag       <= 1'b0;
         divByZeroFlag <= 1'b0;
         case (sel)
            OP_ADD: begin
               accReg   <= addRes;
               zeroFlag <= (addRes == '0);
            end
            OP_SUB: begin
               accReg   <= subRes;
               zeroFlag <= (subRes == '0);
               negFlag  <= (num1 < num2);
            end
            OP_REM: divByZeroFlag <= (num2 == '0);
            default: ;
         endcase
      end else if (state == BUSY) begin
         accReg  <= stepNext;
         counter <= counter - CNT_ONE;
         if (mulOp) aReg <= aReg >> 1;
         else       aReg <= aReg << 1;
         if (counter == CNT_ONE) zeroFlag <= (stepNext == '0);
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a driver pushes reference-model results, a monitor checks responses.
module tb_seq_alu;
   localparam int W     = 3;
   localparam int RES_W = 2*W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     num1 = '0;
   logic [W-1:0]     num2 = '0;
   logic [1:0]       sel = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [RES_W-1:0] result;
   logic             zeroFlag;
   logic             negFlag;
   logic             divByZeroFlag;

   typedef struct {
      int res;
      bit z;
      bit n;
      bit d;
      int lat;
      int acc;
   } expT;

   expT scoreboard[$];
   int  compared = 0;
   int  mismatched = 0;
   int  cycle = 0;
   bit  holdOff = 1'b0;
   bit  seenValid = 1'b0;

   seq_alu #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .num1(num1), .num2(num2), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zeroFlag(zeroFlag), .negFlag(negFlag), .divByZeroFlag(divByZeroFlag)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   // Arithmetic reference computed with plain integers.
   function automatic expT model(input int a, input int b, input int s);
      expT e;
      int  r;
      e.n = 0;
      e.d = 0;
      e.lat = 1;
      case (s)
         0: r = a + b;
         1: begin r = a - b; e.n = (a < b); end
         2: begin r = a * b; e.lat = W + 1; end
         default: begin
            if (b == 0) begin r = 0; e.d = 1; end
            else begin r = a % b; e.lat = W + 1; end
         end
      endcase
      e.res = r & ((1 << RES_W) - 1);
      e.z = e.d ? 1'b0 : (e.res == 0);
      e.acc = 0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic applyStimulus(input int a, input int b, input int s);
      int  guard = 0;
      expT e;
      @(posedge clk); #1;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         checkOutput("acceptTimeout", 0, 1);
         return;
      end
      num1 = W'(a);
      num2 = W'(b);
      sel = 2'(s);
      in_valid = 1'b1;
      e = model(a, b, s);
      e.acc = cycle + 1;
      scoreboard.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      num1 = W'($urandom);
      num2 = W'($urandom);
      sel = 2'($urandom);
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (!holdOff) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: checks every cycle a response is presented, pops on handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpectedValid", 1, 0);
         end else begin
            if (!seenValid) begin
               seenValid = 1'b1;
               checkOutput("latency", cycle - scoreboard[0].acc + 1, scoreboard[0].lat);
            end
            checkOutput("result", int'(result), scoreboard[0].res);
            checkOutput("zeroFlag", int'(zeroFlag), int'(scoreboard[0].z));
            checkOutput("negFlag", int'(negFlag), int'(scoreboard[0].n));
            checkOutput("divByZeroFlag", int'(divByZeroFlag), int'(scoreboard[0].d));
            if (out_ready) begin
               void'(scoreboard.pop_front());
               seenValid = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dirA[11] = '{3, 2, 5, 7, 7, 6, 5, 0, 7, 0, 7};
      int dirB[11] = '{4, 5, 5, 7, 3, 3, 0, 0, 7, 7, 0};
      int dirS[11] = '{0, 1, 1, 2, 3, 3, 3, 0, 0, 1, 2};
      int guard;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetInReady", int'(in_ready), 1);
      checkOutput("resetOutValid", int'(out_valid), 0);
      checkOutput("resetResult", int'(result), 0);
      checkOutput("resetFlags", int'({zeroFlag, negFlag, divByZeroFlag}), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) applyStimulus(dirA[i], dirB[i], dirS[i]);

      // Back-pressure: response must hold while in_valid pulses are ignored.
      guard = 0;
      while (scoreboard.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
      holdOff = 1'b1;
      out_ready = 1'b0;
      applyStimulus(5, 6, 2);
      guard = 0;
      while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
      checkOutput("bpValid", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         num1 = W'($urandom);
         num2 = W'($urandom);
         sel = 2'($urandom);
         checkOutput("bpInReady", int'(in_ready), 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bpIdleInReady", int'(in_ready), 1);
      checkOutput("bpIdleOutValid", int'(out_valid), 0);
      holdOff = 1'b0;

      // Reset in the middle of a multiply aborts it with no response.
      applyStimulus(7, 7, 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abortOutValid", int'(out_valid), 0);
      checkOutput("abortInReady", int'(in_ready), 1);
      checkOutput("abortResult", int'(result), 0);
      scoreboard.delete();
      seenValid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(3, 1, 0);

      for (int i = 0; i < 80; i++)
         applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

      guard = 0;
      while (scoreboard.size() != 0 && guard < 500) begin @(posedge clk); #1; guard++; end
      checkOutput("drainPending", scoreboard.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
